// File: rtl/cw305_reg_mailbox_if.sv
// Register front-end strobes plus the core-side TX/RX streams of the mailbox.
// The mailbox attaches as slave; the host front-end/core model drives the master side.
interface cw305_reg_mailbox_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pDATA_WIDTH   = 32
);
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
  logic                                 reg_read;
  logic                                 reg_write;
  logic                                 reg_addrvalid;
  logic [7:0]                           write_data;
  logic [7:0]                           read_data;
  logic [pDATA_WIDTH-1:0]               O_tx_data;
  logic                                 O_tx_valid;
  logic                                 I_tx_ready;
  logic [pDATA_WIDTH-1:0]               I_rx_data;
  logic                                 I_rx_valid;
  logic                                 O_rx_ready;
  logic                                 O_irq;

  modport slave (
    input  reg_address, reg_bytecnt, reg_read, reg_write, reg_addrvalid, write_data,
    input  I_tx_ready, I_rx_data, I_rx_valid,
    output read_data, O_tx_data, O_tx_valid, O_rx_ready, O_irq
  );

  modport master (
    output reg_address, reg_bytecnt, reg_read, reg_write, reg_addrvalid, write_data,
    output I_tx_ready, I_rx_data, I_rx_valid,
    input  read_data, O_tx_data, O_tx_valid, O_rx_ready, O_irq
  );
endinterface

// File: rtl/cw305_reg_mailbox.sv
// Byte-wide register mailbox: TX FIFO (host->core) committed on the last byte,
// RX FIFO (core->host) popped on the last byte read, with status, flush and sticky errors.
module cw305_reg_mailbox #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pDATA_WIDTH   = 32,
  parameter int pDEPTH        = 4,
  parameter logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] pREG_BASE = '0
) (
  input  logic                usb_clk,
  input  logic                reset_n,
  cw305_reg_mailbox_if.slave  bus
);

  localparam int NB  = pDATA_WIDTH / 8;
  localparam int L   = NB - 1;
  localparam int AW  = $clog2(pDEPTH);
  localparam int CW  = AW + 1;
  localparam int RAW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int BCW = pBYTECNT_SIZE;

  typedef logic [RAW-1:0] addr_t;
  localparam addr_t A_TX   = pREG_BASE;
  localparam addr_t A_RX   = addr_t'(pREG_BASE + addr_t'(1));
  localparam addr_t A_STAT = addr_t'(pREG_BASE + addr_t'(2));
  localparam addr_t A_CTRL = addr_t'(pREG_BASE + addr_t'(3));

  // register state
  logic [NB-1:0][7:0]     stage_q, stage_d;
  logic                   commit_seen_q, pop_seen_q;
  logic [AW-1:0]          tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0]          rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                   tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic                   irq_en_q, irq_en_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] tx_mem [pDEPTH];
  logic [pDATA_WIDTH-1:0] rx_mem [pDEPTH];

  logic wr, rd, hit_tx, hit_rx, hit_stat, hit_ctrl, bc_last;
  logic commit_lvl, pop_lvl, commit, pop_edge, ctrl_wr;
  logic tx_flush, rx_flush, clr_ovf, clr_udf;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, ovf_set, udf_set;
  logic [NB-1:0][7:0]     commit_word;
  logic [pDATA_WIDTH-1:0] tx_head, rx_head;

  assign wr       = bus.reg_addrvalid & bus.reg_write;
  assign rd       = bus.reg_addrvalid & bus.reg_read;
  assign hit_tx   = bus.reg_address == A_TX;
  assign hit_rx   = bus.reg_address == A_RX;
  assign hit_stat = bus.reg_address == A_STAT;
  assign hit_ctrl = bus.reg_address == A_CTRL;
  assign bc_last  = bus.reg_bytecnt == BCW'(L);

  // Commit/pop fire only on the first cycle of a held last-byte access.
  assign commit_lvl = wr & hit_tx & bc_last;
  assign pop_lvl    = rd & hit_rx & bc_last;
  assign commit     = commit_lvl & ~commit_seen_q;
  assign pop_edge   = pop_lvl & ~pop_seen_q;

  assign ctrl_wr  = wr & hit_ctrl & (bus.reg_bytecnt == '0);
  assign tx_flush = ctrl_wr & bus.write_data[0];
  assign rx_flush = ctrl_wr & bus.write_data[1];
  assign clr_ovf  = ctrl_wr & bus.write_data[2];
  assign clr_udf  = ctrl_wr & bus.write_data[3];

  assign tx_full  = tx_cnt_q == CW'(pDEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == CW'(pDEPTH);
  assign rx_empty = rx_cnt_q == '0;

  // Flush wins over anything touching the same FIFO in that cycle.
  assign tx_push = commit & ~tx_full & ~tx_flush;
  assign tx_pop  = ~tx_empty & bus.I_tx_ready & ~tx_flush;
  assign ovf_set = commit & tx_full & ~tx_flush;
  assign rx_push = bus.I_rx_valid & ~rx_full & ~rx_flush;
  assign rx_pop  = pop_edge & ~rx_empty & ~rx_flush;
  assign udf_set = pop_edge & rx_empty & ~rx_flush;

  assign tx_head = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign rx_head = rx_empty ? '0 : rx_mem[rx_rp_q];

  always_comb begin
    commit_word    = stage_q;
    commit_word[L] = bus.write_data;
  end

  always_comb begin
    stage_d = stage_q;
    if (tx_flush) begin
      stage_d = '0;
    end else begin
      for (int i = 0; i < L; i++) begin
        if (wr && hit_tx && bus.reg_bytecnt == BCW'(i)) stage_d[i] = bus.write_data;
      end
    end
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    if (tx_flush) begin
      tx_cnt_d = '0;
      tx_wp_d  = '0;
      tx_rp_d  = '0;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    if (rx_flush) begin
      rx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
    end else begin
      if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  // A same-cycle set beats a clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    irq_en_d = irq_en_q;
    if (clr_ovf) tx_ovf_d = 1'b0;
    if (ovf_set) tx_ovf_d = 1'b1;
    if (clr_udf) rx_udf_d = 1'b0;
    if (udf_set) rx_udf_d = 1'b1;
    if (ctrl_wr) irq_en_d = bus.write_data[4];
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (hit_tx) begin
        for (int i = 0; i < L; i++) begin
          if (bus.reg_bytecnt == BCW'(i)) rdata_d = stage_q[i];
        end
      end else if (hit_rx) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.reg_bytecnt == BCW'(i)) rdata_d = rx_head[8*i +: 8];
        end
      end else if (hit_stat) begin
        case (bus.reg_bytecnt)
          BCW'(0): rdata_d = {4'b0, rx_empty, rx_full, tx_empty, tx_full};
          BCW'(1): rdata_d = 8'(tx_cnt_q);
          BCW'(2): rdata_d = 8'(rx_cnt_q);
          BCW'(3): rdata_d = {6'b0, rx_udf_q, tx_ovf_q};
          default: rdata_d = '0;
        endcase
      end else if (hit_ctrl) begin
        if (bus.reg_bytecnt == '0) rdata_d = {3'b0, irq_en_q, 4'b0};
      end
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q       <= '0;
      commit_seen_q <= 1'b0;
      pop_seen_q    <= 1'b0;
      tx_wp_q       <= '0;
      tx_rp_q       <= '0;
      tx_cnt_q      <= '0;
      rx_wp_q       <= '0;
      rx_rp_q       <= '0;
      rx_cnt_q      <= '0;
      tx_ovf_q      <= 1'b0;
      rx_udf_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      stage_q       <= stage_d;
      commit_seen_q <= commit_lvl;
      pop_seen_q    <= pop_lvl;
      tx_wp_q       <= tx_wp_d;
      tx_rp_q       <= tx_rp_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_wp_q       <= rx_wp_d;
      rx_rp_q       <= rx_rp_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_udf_q      <= rx_udf_d;
      irq_en_q      <= irq_en_d;
      rdata_q       <= rdata_d;
    end
  end

  // Storage is not reset; heads are masked to zero while the FIFO is empty.
  always_ff @(posedge usb_clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= commit_word;
    if (rx_push) rx_mem[rx_wp_q] <= bus.I_rx_data;
  end

  assign bus.read_data  = rdata_q;
  assign bus.O_tx_data  = tx_head;
  assign bus.O_tx_valid = ~tx_empty;
  assign bus.O_rx_ready = ~rx_full;
  assign bus.O_irq      = irq_en_q & ~rx_empty;

endmodule
